// File: rtl/display_pkg.sv
// Shared display definitions: 640x480@60 mode timing, coordinate width and
// helpers for the total line/frame lengths.
package display_pkg;

  localparam int unsigned DISP_CORDW = 10;
  localparam int unsigned DISP_FCW   = 16;

  // 640x480@60 horizontal timing (pixels)
  localparam int unsigned VGA_H_RES  = 640;
  localparam int unsigned VGA_H_FP   = 16;
  localparam int unsigned VGA_H_SYNC = 96;
  localparam int unsigned VGA_H_BP   = 48;

  // 640x480@60 vertical timing (lines)
  localparam int unsigned VGA_V_RES  = 480;
  localparam int unsigned VGA_V_FP   = 10;
  localparam int unsigned VGA_V_SYNC = 2;
  localparam int unsigned VGA_V_BP   = 33;

  // Sync polarities: 0 = active-low
  localparam bit VGA_H_POL = 1'b0;
  localparam bit VGA_V_POL = 1'b0;

  function automatic int unsigned h_total(input int unsigned res, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return res + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned res, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return res + fp + sync + bp;
  endfunction

endpackage

// File: rtl/display_timing.sv
// Display timing generator for the pixel-clock domain. Free-running next-position
// counters (hx, vy) feed a single register stage, so every output in a cycle
// describes the same pixel (sx, sy).
module display_timing
  import display_pkg::*;
#(
  parameter int unsigned CORDW  = DISP_CORDW,
  parameter int unsigned H_RES  = VGA_H_RES,
  parameter int unsigned H_FP   = VGA_H_FP,
  parameter int unsigned H_SYNC = VGA_H_SYNC,
  parameter int unsigned H_BP   = VGA_H_BP,
  parameter int unsigned V_RES  = VGA_V_RES,
  parameter int unsigned V_FP   = VGA_V_FP,
  parameter int unsigned V_SYNC = VGA_V_SYNC,
  parameter int unsigned V_BP   = VGA_V_BP,
  parameter bit          H_POL  = VGA_H_POL,
  parameter bit          V_POL  = VGA_V_POL,
  parameter int unsigned FCW    = DISP_FCW
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line,
  output logic             frame,
  output logic             vblank,
  output logic [FCW-1:0]   frame_cnt
);

  localparam int unsigned H_TOTAL = h_total(H_RES, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_RES, V_FP, V_SYNC, V_BP);
  localparam int unsigned EW      = CORDW + 1;

  // Compare thresholds are one bit wider than the counters so a sync/blank
  // boundary equal to 2**CORDW does not wrap to zero.
  localparam logic [CORDW:0] H_LAST = EW'(H_TOTAL - 1);
  localparam logic [CORDW:0] V_LAST = EW'(V_TOTAL - 1);
  localparam logic [CORDW:0] H_ACT  = EW'(H_RES);
  localparam logic [CORDW:0] V_ACT  = EW'(V_RES);
  localparam logic [CORDW:0] HS_BEG = EW'(H_RES + H_FP);
  localparam logic [CORDW:0] HS_END = EW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW:0] VS_BEG = EW'(V_RES + V_FP);
  localparam logic [CORDW:0] VS_END = EW'(V_RES + V_FP + V_SYNC);

  if ((64'd1 << CORDW) < 64'(H_TOTAL) || (64'd1 << CORDW) < 64'(V_TOTAL)) begin : g_cordw_check
    $error("display_timing: CORDW too narrow for H_TOTAL/V_TOTAL");
  end

  logic [CORDW-1:0] hx, vy;
  logic [CORDW-1:0] hx_d, vy_d;
  logic [CORDW:0]   hx_e, vy_e;
  logic             first_done, first_done_d;
  logic             hsync_d, vsync_d, de_d, line_d, frame_d, vblank_d;
  logic [FCW-1:0]   frame_cnt_d;

  assign hx_e = {1'b0, hx};
  assign vy_e = {1'b0, vy};

  // Next position and the output values describing the pixel at (hx, vy).
  always_comb begin
    hx_d = hx + 1'b1;
    vy_d = vy;
    if (hx_e == H_LAST) begin
      hx_d = '0;
      vy_d = (vy_e == V_LAST) ? '0 : vy + 1'b1;
    end

    hsync_d  = ((hx_e >= HS_BEG) && (hx_e < HS_END)) ? H_POL : ~H_POL;
    vsync_d  = ((vy_e >= VS_BEG) && (vy_e < VS_END)) ? V_POL : ~V_POL;
    de_d     = (hx_e < H_ACT) && (vy_e < V_ACT);
    line_d   = (hx == '0);
    frame_d  = line_d && (vy == '0);
    vblank_d = line_d && (vy_e == V_ACT);

    // The first frame start after reset is frame 0, so it does not count.
    first_done_d = first_done | frame_d;
    frame_cnt_d  = frame_cnt;
    if (frame_d && first_done) begin
      frame_cnt_d = frame_cnt + 1'b1;
    end
  end

  // Advance the counters and register every output from the same position.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      hx         <= '0;
      vy         <= '0;
      first_done <= 1'b0;
      sx         <= '0;
      sy         <= '0;
      hsync      <= ~H_POL;
      vsync      <= ~V_POL;
      de         <= 1'b0;
      line       <= 1'b0;
      frame      <= 1'b0;
      vblank     <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      hx         <= hx_d;
      vy         <= vy_d;
      first_done <= first_done_d;
      sx         <= hx;
      sy         <= vy;
      hsync      <= hsync_d;
      vsync      <= vsync_d;
      de         <= de_d;
      line       <= line_d;
      frame      <= frame_d;
      vblank     <= vblank_d;
      frame_cnt  <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_display_timing.sv
// Scoreboard bench for display_timing: a 640x480 instance checked against
// hand-computed vectors and per-line counts, and a tiny 15x8 mode instance
// (FCW=2) checked every cycle against a position model and per-frame counts.
`timescale 1ns/1ps
module tb_display_timing;

  logic clk_pix = 1'b0;
  logic rst_n;
  always #5 clk_pix = ~clk_pix;

  // Default-mode DUT
  logic [9:0]  d_sx, d_sy;
  logic        d_hs, d_vs, d_de, d_line, d_frame, d_vb;
  logic [15:0] d_fc;

  // Small-mode DUT: H 8+2+3+2=15, V 4+1+2+1=8, 120 cycles per frame, hsync active-high
  logic [3:0]  s_sx, s_sy;
  logic        s_hs, s_vs, s_de, s_line, s_frame, s_vb;
  logic [1:0]  s_fc;

  display_timing dut_def (
    .clk_pix   (clk_pix),
    .rst_n     (rst_n),
    .sx        (d_sx),
    .sy        (d_sy),
    .hsync     (d_hs),
    .vsync     (d_vs),
    .de        (d_de),
    .line      (d_line),
    .frame     (d_frame),
    .vblank    (d_vb),
    .frame_cnt (d_fc)
  );

  display_timing #(
    .CORDW(4), .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b0), .FCW(2)
  ) dut_sm (
    .clk_pix   (clk_pix),
    .rst_n     (rst_n),
    .sx        (s_sx),
    .sy        (s_sy),
    .hsync     (s_hs),
    .vsync     (s_vs),
    .de        (s_de),
    .line      (s_line),
    .frame     (s_frame),
    .vblank    (s_vb),
    .frame_cnt (s_fc)
  );

  typedef struct {
    int          cyc;
    logic [31:0] sx, sy, fc;
    logic        hs, vs, de, line, frame, vb;
  } exp_t;

  exp_t q_sm[$];
  exp_t q_dir[$];
  int   checks = 0;
  int   passed = 0;

  function automatic exp_t mk(int cyc, int sx, int sy, logic hs, logic vs, logic de,
                              logic ln, logic fr, logic vb, int fc);
    exp_t e;
    e.cyc = cyc; e.sx = sx; e.sy = sy; e.hs = hs; e.vs = vs; e.de = de;
    e.line = ln; e.frame = fr; e.vb = vb; e.fc = fc;
    return e;
  endfunction

  function automatic exp_t act_def(int cyc);
    return mk(cyc, 0, 0, d_hs, d_vs, d_de, d_line, d_frame, d_vb, 0);
  endfunction

  function automatic string fmt(exp_t r);
    return $sformatf("(%0d,%0d) hs=%b vs=%b de=%b ln=%b fr=%b vb=%b fc=%0d",
                     r.sx, r.sy, r.hs, r.vs, r.de, r.line, r.frame, r.vb, r.fc);
  endfunction

  task automatic cmp(string name, exp_t e, exp_t a);
    checks++;
    if (a.sx !== e.sx || a.sy !== e.sy || a.fc !== e.fc || a.hs !== e.hs || a.vs !== e.vs ||
        a.de !== e.de || a.line !== e.line || a.frame !== e.frame || a.vb !== e.vb)
      $display("FAIL %s cyc=%0d: got %s, expected %s", name, e.cyc, fmt(a), fmt(e));
    else
      passed++;
  endtask

  task automatic check_int(string name, int got, int exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    else passed++;
  endtask

  // Position model for the small mode, from cycles since reset release.
  function automatic exp_t sm_model(int n);
    int p, x, y;
    p = n % 120;
    x = p % 15;
    y = p / 15;
    return mk(n, x, y, (x >= 10 && x <= 12), !(y == 5 || y == 6), (x < 8 && y < 4),
              (x == 0), (p == 0), (p == 60), (n / 120) % 4);
  endfunction

  // Expectation source: one small-mode record per clock while out of reset.
  initial begin
    int n = 0;
    forever begin
      @(posedge clk_pix or negedge rst_n);
      if (!rst_n) n = 0;
      else begin
        q_sm.push_back(sm_model(n));
        n++;
      end
    end
  end

  // Monitor: compares outputs mid-cycle, and just after any reset assertion.
  initial begin
    exp_t e, a;
    int p;
    int hs_low = 0, de_cnt = 0, last_line = -1;
    int sm_de = 0, sm_vsa = 0, sm_vb = 0, sm_ln = 0, last_frame = -1;
    forever begin
      @(negedge clk_pix or negedge rst_n);
      #1;
      if (!rst_n) begin
        a = act_def(-1); a.sx = 32'(d_sx); a.sy = 32'(d_sy); a.fc = 32'(d_fc);
        cmp("reset_def", mk(-1, 0, 0, 1, 1, 0, 0, 0, 0, 0), a);
        cmp("reset_sm", mk(-1, 0, 0, 0, 1, 0, 0, 0, 0, 0),
            mk(-1, 32'(s_sx), 32'(s_sy), s_hs, s_vs, s_de, s_line, s_frame, s_vb, 32'(s_fc)));
        hs_low = 0; de_cnt = 0; last_line = -1;
        sm_de = 0; sm_vsa = 0; sm_vb = 0; sm_ln = 0; last_frame = -1;
      end else if (q_sm.size() > 0) begin
        e = q_sm.pop_front();
        a = mk(e.cyc, 32'(s_sx), 32'(s_sy), s_hs, s_vs, s_de, s_line, s_frame, s_vb, 32'(s_fc));
        cmp("sm_model", e, a);

        // Small mode per-frame totals
        p = e.cyc % 120;
        sm_de  += int'(s_de);
        sm_vsa += int'(!s_vs);
        sm_vb  += int'(s_vb);
        sm_ln  += int'(s_line);
        if (s_frame) begin
          if (last_frame >= 0) check_int("sm_frame_period", e.cyc - last_frame, 120);
          last_frame = e.cyc;
        end
        if (p == 119) begin
          check_int("sm_de_per_frame", sm_de, 32);
          check_int("sm_vsync_per_frame", sm_vsa, 30);
          check_int("sm_vblank_per_frame", sm_vb, 1);
          check_int("sm_lines_per_frame", sm_ln, 8);
          sm_de = 0; sm_vsa = 0; sm_vb = 0; sm_ln = 0;
        end

        // Default mode: first-line totals and line strobe period
        if (e.cyc < 800) begin
          hs_low += int'(!d_hs);
          de_cnt += int'(d_de);
        end
        if (e.cyc == 799) begin
          check_int("def_hsync_low_per_line", hs_low, 96);
          check_int("def_de_per_line", de_cnt, 640);
        end
        if (d_line) begin
          if (last_line >= 0) check_int("def_line_period", e.cyc - last_line, 800);
          last_line = e.cyc;
        end

        while (q_dir.size() > 0 && q_dir[0].cyc <= e.cyc) begin
          exp_t d;
          d = q_dir.pop_front();
          a = act_def(d.cyc); a.sx = 32'(d_sx); a.sy = 32'(d_sy); a.fc = 32'(d_fc);
          cmp("def_vector", d, a);
        end
      end
    end
  end

  // Stimulus: reset, long run, asynchronous mid-frame reset, short restart run.
  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    //            cyc   sx  sy hs vs de ln fr vb fc
    q_dir.push_back(mk(0,    0,  0, 1, 1, 1, 1, 1, 0, 0));
    q_dir.push_back(mk(1,    1,  0, 1, 1, 1, 0, 0, 0, 0));
    q_dir.push_back(mk(639,  639, 0, 1, 1, 1, 0, 0, 0, 0));
    q_dir.push_back(mk(640,  640, 0, 1, 1, 0, 0, 0, 0, 0));
    q_dir.push_back(mk(655,  655, 0, 1, 1, 0, 0, 0, 0, 0));
    q_dir.push_back(mk(656,  656, 0, 0, 1, 0, 0, 0, 0, 0));
    q_dir.push_back(mk(751,  751, 0, 0, 1, 0, 0, 0, 0, 0));
    q_dir.push_back(mk(752,  752, 0, 1, 1, 0, 0, 0, 0, 0));
    q_dir.push_back(mk(799,  799, 0, 1, 1, 0, 0, 0, 0, 0));
    q_dir.push_back(mk(800,  0,   1, 1, 1, 1, 1, 0, 0, 0));
    q_dir.push_back(mk(1600, 0,   2, 1, 1, 1, 1, 0, 0, 0));
    q_dir.push_back(mk(2399, 799, 2, 1, 1, 0, 0, 0, 0, 0));
    q_dir.push_back(mk(2400, 0,   3, 1, 1, 1, 1, 0, 0, 0));
    q_dir.push_back(mk(2435, 35,  3, 1, 1, 1, 0, 0, 0, 0));
    repeat (10) @(posedge clk_pix);
    @(negedge clk_pix);
    rst_n = 1'b1;

    // Small mode is at (5,2) of its 21st frame on cycle 2435.
    repeat (2436) @(posedge clk_pix);
    @(negedge clk_pix);
    #2 rst_n = 1'b0;
    check_int("def_vectors_reached", q_dir.size(), 0);
    q_dir.push_back(mk(0,  0,  0, 1, 1, 1, 1, 1, 0, 0));
    q_dir.push_back(mk(1,  1,  0, 1, 1, 1, 0, 0, 0, 0));
    q_dir.push_back(mk(49, 49, 0, 1, 1, 1, 0, 0, 0, 0));
    repeat (3) @(posedge clk_pix);
    @(negedge clk_pix);
    rst_n = 1'b1;

    repeat (50) @(posedge clk_pix);
    @(negedge clk_pix);
    #2;
    check_int("restart_vectors_reached", q_dir.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
